// File: rtl/dm1_2x8_reg.sv
// Registered 1:2 byte demultiplexer: one valid/ready input stream is steered by sel into two
// one-entry output lanes. Optional per-lane accept counters are built when DM_CNT_EN is defined.
module dm1_2x8_reg #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [W-1:0]     out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [W-1:0]     out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_e;

  lane_state_e state0_q, state0_d;
  lane_state_e state1_q, state1_d;
  logic [W-1:0] data0_q, data0_d;
  logic [W-1:0] data1_q, data1_d;

  logic take0, take1;
  logic tgt_free;
  logic acc, acc0, acc1;

  // A new accept wins over a take (pass-through keeps the lane FULL); clr wins over both.
  function automatic lane_state_e lane_next(lane_state_e cur, logic take, logic accept,
                                            logic flush);
    lane_state_e nxt;
    nxt = cur;
    if (flush)       nxt = EMPTY;
    else if (accept) nxt = FULL;
    else if (take)   nxt = EMPTY;
    return nxt;
  endfunction

  // NOTE: every output of this block gets a value on every path, so no latch is inferred.
  always_comb begin
    take0    = (state0_q == FULL) & out0_ready;
    take1    = (state1_q == FULL) & out1_ready;
    tgt_free = sel ? ((state1_q == EMPTY) | take1) : ((state0_q == EMPTY) | take0);
    in_ready = !clr & tgt_free;
    acc      = in_valid & in_ready;
    acc0     = acc & !sel;
    acc1     = acc & sel;

    state0_d = lane_next(state0_q, take0, acc0, clr);
    state1_d = lane_next(state1_q, take1, acc1, clr);
    data0_d  = acc0 ? in_data : data0_q;
    data1_d  = acc1 ? in_data : data1_q;
  end

  // NOTE: state flops use non-blocking assignments so all lanes update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state0_q <= EMPTY;
      state1_q <= EMPTY;
      data0_q  <= '0;
      data1_q  <= '0;
    end else begin
      state0_q <= state0_d;
      state1_q <= state1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
    end
  end

  assign out0_valid = (state0_q == FULL);
  assign out1_valid = (state1_q == FULL);
  assign out0_data  = data0_q;
  assign out1_data  = data1_q;

`ifdef DM_CNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Counters are deliberately untouched by clr; they wrap naturally at 2^CNT_W.
  always_comb begin
    cnt0_d = acc0 ? cnt0_q + CNT_W'(1) : cnt0_q;
    cnt1_d = acc1 ? cnt1_q + CNT_W'(1) : cnt1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule
